// File: rtl/washer_pkg.sv
// Shared defaults and debug types for the washer plant model.
package washer_pkg;

  localparam int DEF_LEVEL_W     = 8;
  localparam int DEF_FULL_LEVEL  = 200;
  localparam int DEF_FILL_RATE   = 4;
  localparam int DEF_DRAIN_RATE  = 8;
  localparam int DEF_TIMER_W     = 16;
  localparam int DEF_CYCLE_TICKS = 1000;
  localparam int DEF_SPIN_TICKS  = 500;

  // First illegal command that latched the fault; NONE means healthy.
  typedef enum logic [1:0] {
    NONE             = 2'd0,
    VALVE_CONFLICT   = 2'd1,
    UNLOCKED_ACTUATE = 2'd2
  } fault_cause_e;

endpackage

// File: rtl/washer_timer.sv
// Run-length timer: expires after TICKS consecutive run cycles, clears as soon as run drops.
module washer_timer #(
  parameter int TIMER_W = 16,
  parameter int TICKS   = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic hold,
  output logic expired
);

  localparam logic [TIMER_W-1:0] TERM = TIMER_W'(TICKS - 1);

  logic [TIMER_W-1:0] count_q, count_d;
  logic               expired_q, expired_d;

  // Next-state: freeze on hold, clear when idle, saturate at the terminal count.
  always_comb begin
    count_d   = count_q;
    expired_d = expired_q;
    if (hold) begin
      count_d   = count_q;
      expired_d = expired_q;
    end else if (!run) begin
      count_d   = {TIMER_W{1'b0}};
      expired_d = 1'b0;
    end else if (count_q == TERM) begin
      count_d   = count_q;
      expired_d = 1'b1;
    end else begin
      count_d   = count_q + TIMER_W'(1);
      expired_d = 1'b0;
    end
  end

  // Timer state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q   <= {TIMER_W{1'b0}};
      expired_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;

endmodule

// File: rtl/washer_plant_model.sv
// Washer plant responder: drum level datapath, wash/spin timers and sticky illegal-command fault.
module washer_plant_model
  import washer_pkg::*;
#(
  parameter int LEVEL_W     = DEF_LEVEL_W,
  parameter int FULL_LEVEL  = DEF_FULL_LEVEL,
  parameter int FILL_RATE   = DEF_FILL_RATE,
  parameter int DRAIN_RATE  = DEF_DRAIN_RATE,
  parameter int TIMER_W     = DEF_TIMER_W,
  parameter int CYCLE_TICKS = DEF_CYCLE_TICKS,
  parameter int SPIN_TICKS  = DEF_SPIN_TICKS
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               fill_valve_on,
  input  logic               drain_valve_on,
  input  logic               motor_on,
  input  logic               door_lock,
  output logic               filled,
  output logic               drained,
  output logic               cycle_timeout,
  output logic               spin_timeout,
  output logic [LEVEL_W-1:0] water_level,
  output logic               fault
);

  localparam logic [LEVEL_W:0]   FULL_X  = (LEVEL_W + 1)'(FULL_LEVEL);
  localparam logic [LEVEL_W:0]   FILL_X  = (LEVEL_W + 1)'(FILL_RATE);
  localparam logic [LEVEL_W:0]   DRAIN_X = (LEVEL_W + 1)'(DRAIN_RATE);
  localparam logic [LEVEL_W-1:0] FULL_L  = LEVEL_W'(FULL_LEVEL);

  logic [LEVEL_W-1:0] level_q, level_d;
  fault_cause_e       cause_q, cause_d;
  logic               valve_conflict_s, unlocked_s, fault_s;
  logic [LEVEL_W:0]   fill_sum_s, drain_diff_s;

  assign valve_conflict_s = fill_valve_on & drain_valve_on;
  assign unlocked_s       = (fill_valve_on | motor_on) & ~door_lock;
  assign fault_s          = (cause_q != NONE);

  // One extra bit: fill overshoot is clamped, drain underflow shows up as a borrow in the MSB.
  assign fill_sum_s   = {1'b0, level_q} + FILL_X;
  assign drain_diff_s = {1'b0, level_q} - DRAIN_X;

  // Level next-state; the offending cycle of an illegal command is already suppressed.
  always_comb begin
    level_d = level_q;
    if (fault_s || valve_conflict_s || unlocked_s) begin
      level_d = level_q;
    end else if (fill_valve_on && door_lock) begin
      level_d = (fill_sum_s >= FULL_X) ? FULL_L : fill_sum_s[LEVEL_W-1:0];
    end else if (drain_valve_on) begin
      level_d = drain_diff_s[LEVEL_W] ? {LEVEL_W{1'b0}} : drain_diff_s[LEVEL_W-1:0];
    end else begin
      level_d = level_q;
    end
  end

  // Fault cause latches the first illegal combination and holds until reset.
  always_comb begin
    cause_d = cause_q;
    if (fault_s) begin
      cause_d = cause_q;
    end else if (valve_conflict_s) begin
      cause_d = VALVE_CONFLICT;
    end else if (unlocked_s) begin
      cause_d = UNLOCKED_ACTUATE;
    end else begin
      cause_d = NONE;
    end
  end

  // Level and fault registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level_q <= {LEVEL_W{1'b0}};
      cause_q <= NONE;
    end else begin
      level_q <= level_d;
      cause_q <= cause_d;
    end
  end

  assign water_level = level_q;
  assign filled      = (level_q == FULL_L);
  assign drained     = (level_q == {LEVEL_W{1'b0}});
  assign fault       = fault_s;

  washer_timer #(.TIMER_W(TIMER_W), .TICKS(CYCLE_TICKS)) u_wash_timer (
    .clock   (clock),
    .reset   (reset),
    .run     (motor_on & ~drained),
    .hold    (fault_s),
    .expired (cycle_timeout)
  );

  washer_timer #(.TIMER_W(TIMER_W), .TICKS(SPIN_TICKS)) u_spin_timer (
    .clock   (clock),
    .reset   (reset),
    .run     (drained & (motor_on | drain_valve_on)),
    .hold    (fault_s),
    .expired (spin_timeout)
  );

endmodule

// File: tb/tb_washer_plant_model.sv
// Self-checking bench for washer_plant_model: vector table, directed corner sequences, random vs model.
module tb_washer_plant_model;

  localparam int FULL  = 200;
  localparam int FRATE = 4;
  localparam int DRATE = 8;
  localparam int CT    = 1000;
  localparam int ST    = 500;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       fill = 1'b0, drain = 1'b0, motor = 1'b0, lock = 1'b0;
  logic       filled, drained, cycle_timeout, spin_timeout, fault;
  logic [7:0] water_level;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: level in plain integers, timers as lengths of the current run.
  int m_level, m_wash, m_spin;
  bit m_fault;

  washer_plant_model dut (
    .clock          (clock),
    .reset          (reset),
    .fill_valve_on  (fill),
    .drain_valve_on (drain),
    .motor_on       (motor),
    .door_lock      (lock),
    .filled         (filled),
    .drained        (drained),
    .cycle_timeout  (cycle_timeout),
    .spin_timeout   (spin_timeout),
    .water_level    (water_level),
    .fault          (fault)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ":level"},   int'(water_level),   m_level);
    chk({tag, ":filled"},  int'(filled),        int'(m_level == FULL));
    chk({tag, ":drained"}, int'(drained),       int'(m_level == 0));
    chk({tag, ":cyc_to"},  int'(cycle_timeout), int'(m_wash >= CT));
    chk({tag, ":spin_to"}, int'(spin_timeout),  int'(m_spin >= ST));
    chk({tag, ":fault"},   int'(fault),         int'(m_fault));
  endtask

  task automatic model_step(input bit f, input bit d, input bit m, input bit l);
    bit illegal;
    bit was_drained;
    illegal     = (f && d) || ((f || m) && !l);
    was_drained = (m_level == 0);
    if (!m_fault) begin
      if (!illegal) begin
        if (f && l && !d) m_level = (m_level + FRATE > FULL) ? FULL : m_level + FRATE;
        else if (d && !f) m_level = (m_level < DRATE) ? 0 : m_level - DRATE;
      end
      if (m && !was_drained) m_wash++; else m_wash = 0;
      if (was_drained && (m || d)) m_spin++; else m_spin = 0;
    end
    if (illegal) m_fault = 1'b1;
  endtask

  task automatic cycle(input bit f, input bit d, input bit m, input bit l);
    fill = f; drain = d; motor = m; lock = l;
    @(posedge clock);
    model_step(f, d, m, l);
    #1;
    chk_model("model");
  endtask

  task automatic run(input bit f, input bit d, input bit m, input bit l, input int n);
    for (int i = 0; i < n; i++) cycle(f, d, m, l);
  endtask

  // Asserts reset between clock edges and checks the outputs clear without any edge.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    m_level = 0; m_wash = 0; m_spin = 0; m_fault = 1'b0;
    chk_model("async_rst");
    fill = 1'b0; drain = 1'b0; motor = 1'b0; lock = 1'b0;
    @(posedge clock);
    #1;
    chk_model("rst_hold");
    reset = 1'b0;
  endtask

  typedef struct {
    logic f, d, m, l;
    int   n;
    int   lvl;
    logic fl, dr, ft;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 10,  40, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1,  3,  16, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1,  5,  16, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1,  2,   0, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1,  1,   0, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1,  1,   4, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1,  1,   0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 60, 200, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1,  1, 192, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1,  1, 192, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1,  3, 192, 1'b0, 1'b0, 1'b1};

    do_reset();
    chk("rst_level", int'(water_level), 0);
    chk("rst_drained", int'(drained), 1);
    chk("rst_filled", int'(filled), 0);
    chk("rst_cyc_to", int'(cycle_timeout), 0);
    chk("rst_spin_to", int'(spin_timeout), 0);
    chk("rst_fault", int'(fault), 0);

    // Vector table.
    for (int v = 0; v < 11; v++) begin
      run(tbl[v].f, tbl[v].d, tbl[v].m, tbl[v].l, tbl[v].n);
      chk($sformatf("vec%0d_level", v), int'(water_level), tbl[v].lvl);
      chk($sformatf("vec%0d_filled", v), int'(filled), int'(tbl[v].fl));
      chk($sformatf("vec%0d_drained", v), int'(drained), int'(tbl[v].dr));
      chk($sformatf("vec%0d_fault", v), int'(fault), int'(tbl[v].ft));
    end

    // Fill to full in exactly 50 clocks, then clamp.
    do_reset();
    run(1'b1, 1'b0, 1'b0, 1'b1, 49);
    chk("fill49_level", int'(water_level), 196);
    chk("fill49_filled", int'(filled), 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    chk("fill50_level", int'(water_level), 200);
    chk("fill50_filled", int'(filled), 1);
    run(1'b1, 1'b0, 1'b0, 1'b1, 5);
    chk("fill_clamp", int'(water_level), 200);

    // Wash timeout after exactly CT run edges; clears one edge after motor drops.
    run(1'b0, 1'b0, 1'b1, 1'b1, CT - 1);
    chk("wash_999", int'(cycle_timeout), 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    chk("wash_1000", int'(cycle_timeout), 1);
    run(1'b0, 1'b0, 1'b1, 1'b1, 5);
    chk("wash_hold", int'(cycle_timeout), 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("wash_drop", int'(cycle_timeout), 0);
    run(1'b0, 1'b0, 1'b1, 1'b1, 600);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("wash_600_drop", int'(cycle_timeout), 0);
    run(1'b0, 1'b0, 1'b1, 1'b1, CT - 1);
    chk("wash_restart_999", int'(cycle_timeout), 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    chk("wash_restart_1000", int'(cycle_timeout), 1);

    // Drain to empty in 25 clocks, spin timeout after 500 more drain edges.
    run(1'b0, 1'b1, 1'b0, 1'b1, 24);
    chk("drain24_drained", int'(drained), 0);
    chk("drain24_wash_clr", int'(cycle_timeout), 0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    chk("drain25_drained", int'(drained), 1);
    run(1'b0, 1'b1, 1'b0, 1'b1, ST - 1);
    chk("spin_499", int'(spin_timeout), 0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    chk("spin_500", int'(spin_timeout), 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("spin_drop", int'(spin_timeout), 0);

    // Valve conflict at level 100 freezes the level and latches the fault.
    do_reset();
    run(1'b1, 1'b0, 1'b0, 1'b1, 25);
    chk("pre_conflict_level", int'(water_level), 100);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    chk("conflict_fault", int'(fault), 1);
    chk("conflict_level", int'(water_level), 100);
    run(1'b0, 1'b0, 1'b0, 1'b1, 10);
    run(1'b0, 1'b1, 1'b0, 1'b1, 3);
    chk("conflict_sticky", int'(fault), 1);
    chk("conflict_frozen", int'(water_level), 100);
    do_reset();
    chk("conflict_cleared", int'(fault), 0);

    // Fill with the door unlocked.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("unlocked_level", int'(water_level), 0);
    chk("unlocked_fault", int'(fault), 1);

    // Reset mid-drain at level 120.
    do_reset();
    run(1'b1, 1'b0, 1'b0, 1'b1, 32);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    chk("middrain_level", int'(water_level), 120);
    fill = 1'b0; drain = 1'b1; motor = 1'b0; lock = 1'b1;
    do_reset();
    chk("middrain_rst_level", int'(water_level), 0);
    chk("middrain_rst_drained", int'(drained), 1);

    // Random segments against the model.
    for (int s = 0; s < 70; s++) begin
      bit f, d, m, l;
      int len;
      if ($urandom_range(0, 15) == 0) do_reset();
      if ($urandom_range(0, 19) == 0) begin
        f = 1'($urandom); d = 1'($urandom); m = 1'($urandom); l = 1'($urandom);
      end else begin
        l = 1'b1;
        case ($urandom_range(0, 5))
          0: begin f = 1'b1; d = 1'b0; m = 1'b0; end
          1: begin f = 1'b0; d = 1'b1; m = 1'b0; end
          2: begin f = 1'b0; d = 1'b0; m = 1'b1; end
          3: begin f = 1'b1; d = 1'b0; m = 1'b1; end
          4: begin f = 1'b0; d = 1'b1; m = 1'b1; end
          default: begin f = 1'b0; d = 1'b0; m = 1'b0; end
        endcase
      end
      len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(400, 1100)) : int'($urandom_range(1, 40));
      run(f, d, m, l, len);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
